// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb (with cpu_pkg)
// Brief    : Round-robin sharing of one combinational ALU between requesters.
// Revision : 1.0 - initial release
// ============================================================================

package cpu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } t_alu_op;
endpackage

module alu_share_arb #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  cpu_pkg::t_alu_op [NUM_REQ-1:0]      req_op,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_in1,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_in2,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   input  logic [NUM_REQ-1:0]                  rsp_ready,
   output logic [DATA_W-1:0]                   rsp_data,
   output logic [ID_W-1:0]                     rsp_id,
   output cpu_pkg::t_alu_op                    alu_op,
   output logic [DATA_W-1:0]                   alu_in1,
   output logic [DATA_W-1:0]                   alu_in2,
   input  logic [DATA_W-1:0]                   alu_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } t_state;

   localparam logic [ID_W-1:0] c_last_req = ID_W'(NUM_REQ - 1);

   t_state               r_state;
   t_state               w_state_nxt;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [ID_W-1:0]      r_rsp_id;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [DATA_W-1:0]    r_rsp_data;
   cpu_pkg::t_alu_op     r_alu_op;
   logic [DATA_W-1:0]    r_alu_in1;
   logic [DATA_W-1:0]    r_alu_in2;

   logic                 w_found;
   logic [ID_W-1:0]      w_grant;
   logic                 w_rsp_hs;
   logic                 w_accept;

   // Search above the last winner first, then wrap around to the bottom.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req_valid[i] && (i > int'(r_rr_ptr))) begin
            w_found = 1'b1;
            w_grant = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req_valid[i] && (i <= int'(r_rr_ptr))) begin
            w_found = 1'b1;
            w_grant = ID_W'(i);
         end
      end
   end

   assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_rsp_id];
   assign w_accept = ((r_state == IDLE) || w_rsp_hs) && w_found && !rst;

   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = EXEC;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            if (w_rsp_hs) begin
               w_state_nxt = w_accept ? EXEC : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= c_last_req;
         r_rsp_id    <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_alu_op    <= cpu_pkg::ALU_ADD;
         r_alu_in1   <= '0;
         r_alu_in2   <= '0;
      end else begin
         if (w_accept) begin
            r_alu_op  <= req_op[w_grant];
            r_alu_in1 <= req_in1[w_grant];
            r_alu_in2 <= req_in2[w_grant];
            r_rsp_id  <= w_grant;
            r_rr_ptr  <= w_grant;
         end
         if (r_state == EXEC) begin
            r_rsp_data  <= alu_out;
            r_rsp_valid <= NUM_REQ'(1) << r_rsp_id;
         end else if (w_rsp_hs) begin
            r_rsp_valid <= '0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign alu_op    = r_alu_op;
   assign alu_in1   = r_alu_in1;
   assign alu_in2   = r_alu_in2;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Brief    : Directed self-checking bench for alu_share_arb with a local ALU.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_share_arb;
   import cpu_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   t_alu_op [1:0]        req_op;
   logic [1:0][31:0]     req_in1;
   logic [1:0][31:0]     req_in2;
   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   logic [31:0]          rsp_data;
   logic                 rsp_id;
   t_alu_op              alu_op;
   logic [31:0]          alu_in1;
   logic [31:0]          alu_in2;
   logic [31:0]          alu_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   alu_share_arb #(.NUM_REQ(2), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_in1(req_in1), .req_in2(req_in2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared combinational ALU.
   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:  alu_out = alu_in1 + alu_in2;
         ALU_SUB:  alu_out = alu_in1 - alu_in2;
         ALU_SLL:  alu_out = alu_in1 << alu_in2[4:0];
         ALU_SRL:  alu_out = alu_in1 >> alu_in2[4:0];
         ALU_SRA:  alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
         ALU_SLT:  alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
         ALU_SLTU: alu_out = {31'b0, alu_in1 < alu_in2};
         ALU_XOR:  alu_out = alu_in1 ^ alu_in2;
         ALU_OR:   alu_out = alu_in1 | alu_in2;
         ALU_AND:  alu_out = alu_in1 & alu_in2;
         default:  alu_out = '0;
      endcase
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset_mid_op();
      rst = 1'b1; req_valid = 2'b01; rsp_ready = 2'b00;
      req_op[0] = ALU_ADD; req_in1[0] = 32'd10; req_in2[0] = 32'd5;
      req_op[1] = ALU_ADD; req_in1[1] = 32'd0;  req_in2[1] = 32'd0;
      cyc(); cyc(); #1;
      total_cnt++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b want 00", req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || rsp_id !== 1'b0)
         $display("FAIL rst_rsp: got v=%b d=%h id=%b want 00/0/0", rsp_valid, rsp_data, rsp_id); else pass_cnt++;
      total_cnt++; if (alu_op !== ALU_ADD || alu_in1 !== 32'd0 || alu_in2 !== 32'd0)
         $display("FAIL rst_alu: got op=%0d a=%h b=%h want 0/0/0", alu_op, alu_in1, alu_in2); else pass_cnt++;
      rst = 1'b0; #1;
      total_cnt++; if (req_ready !== 2'b01) $display("FAIL t1_accept: got %b want 01", req_ready); else pass_cnt++;
      cyc();
      req_valid = 2'b00; #1;
      total_cnt++; if (alu_in1 !== 32'd10) $display("FAIL t1_in1: got %h want a", alu_in1); else pass_cnt++;
      rst = 1'b1;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b00 || alu_in1 !== 32'd0 || alu_op !== ALU_ADD)
         $display("FAIL t1_midrst: got v=%b a=%h op=%0d want 00/0/0", rsp_valid, alu_in1, alu_op); else pass_cnt++;
      rst = 1'b0; rsp_ready = 2'b11;
      for (int k = 0; k < 3; k++) begin
         cyc(); #1;
         total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL t1_norsp: cyc %0d got %b want 00", k, rsp_valid); else pass_cnt++;
      end
      req_op[0] = ALU_SUB; req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd5 || rsp_id !== 1'b0)
         $display("FAIL t1_sub: got v=%b d=%h id=%b want 01/5/0", rsp_valid, rsp_data, rsp_id); else pass_cnt++;
      cyc();
   endtask

   task automatic test_single_latency();
      rsp_ready = 2'b11;
      req_op[1] = ALU_SLT; req_in1[1] = 32'hFFFF_FFFF; req_in2[1] = 32'd1;
      req_valid = 2'b10; #1;
      total_cnt++; if (req_ready !== 2'b10) $display("FAIL t2_ready: got %b want 10", req_ready); else pass_cnt++;
      cyc();
      // Short-lived request during EXEC must be ignored.
      req_valid = 2'b01; #1;
      total_cnt++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00)
         $display("FAIL t2_exec: got rdy=%b v=%b want 00/00", req_ready, rsp_valid); else pass_cnt++;
      cyc();
      req_valid = 2'b00; #1;
      total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd1 || rsp_id !== 1'b1)
         $display("FAIL t2_rsp: got v=%b d=%h id=%b want 10/1/1", rsp_valid, rsp_data, rsp_id); else pass_cnt++;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL t2_once: got %b want 00", rsp_valid); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      rst = 1'b1; cyc(); rst = 1'b0;
      rsp_ready = 2'b11;
      req_op[0] = ALU_SLL; req_in1[0] = 32'd1;          req_in2[0] = 32'd3;
      req_op[1] = ALU_SRA; req_in1[1] = 32'hFFFF_FFF8;  req_in2[1] = 32'd2;
      req_valid = 2'b11; #1;
      total_cnt++; if (req_ready !== 2'b01) $display("FAIL t3_first: got %b want 01", req_ready); else pass_cnt++;
      cyc();
      req_valid = 2'b10; #1;
      total_cnt++; if (req_ready !== 2'b00) $display("FAIL t3_exec: got %b want 00", req_ready); else pass_cnt++;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd8 || req_ready !== 2'b10)
         $display("FAIL t3_rsp0: got v=%b d=%h rdy=%b want 01/8/10", rsp_valid, rsp_data, req_ready); else pass_cnt++;
      cyc();
      req_valid = 2'b00; #1;
      total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL t3_gap: got %b want 00", rsp_valid); else pass_cnt++;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hFFFF_FFFE || rsp_id !== 1'b1)
         $display("FAIL t3_rsp1: got v=%b d=%h id=%b want 10/fffffffe/1", rsp_valid, rsp_data, rsp_id); else pass_cnt++;
      cyc();
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_rdy [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      logic [1:0]  exp_vld [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      logic [31:0] exp_dat [8] = '{32'h0, 32'h0, 32'hAAAA_FFFF, 32'h0, 32'hEDCB_5678, 32'h0, 32'hAAAA_FFFF, 32'h0};
      rsp_ready = 2'b11;
      req_op[0] = ALU_XOR; req_in1[0] = 32'hA5A5_0000; req_in2[0] = 32'h0F0F_FFFF;
      req_op[1] = ALU_XOR; req_in1[1] = 32'h1234_5678; req_in2[1] = 32'hFFFF_0000;
      req_valid = 2'b11;
      for (int i = 0; i < 8; i++) begin
         #1;
         total_cnt++; if (req_ready !== exp_rdy[i]) $display("FAIL t4_grant: cyc %0d got %b want %b", i, req_ready, exp_rdy[i]); else pass_cnt++;
         total_cnt++; if (rsp_valid !== exp_vld[i] || (exp_vld[i] != 2'b00 && rsp_data !== exp_dat[i]))
            $display("FAIL t4_rsp: cyc %0d got v=%b d=%h want %b/%h", i, rsp_valid, rsp_data, exp_vld[i], exp_dat[i]); else pass_cnt++;
         cyc();
      end
      req_valid = 2'b00; #1;
      total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hEDCB_5678 || rsp_id !== 1'b1)
         $display("FAIL t4_last: got v=%b d=%h id=%b want 10/edcb5678/1", rsp_valid, rsp_data, rsp_id); else pass_cnt++;
      cyc();
   endtask

   task automatic test_backpressure();
      rsp_ready = 2'b00;
      req_op[0] = ALU_AND; req_in1[0] = 32'hFF00_FF00; req_in2[0] = 32'h0F0F_0F0F;
      req_op[1] = ALU_OR;  req_in1[1] = 32'h00F0_0000; req_in2[1] = 32'h0000_000F;
      req_valid = 2'b11; #1;
      total_cnt++; if (req_ready !== 2'b01) $display("FAIL t5_first: got %b want 01", req_ready); else pass_cnt++;
      cyc();
      req_valid = 2'b10;
      cyc();
      for (int k = 0; k < 5; k++) begin
         #1;
         total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0F00_0F00 || req_ready !== 2'b00)
            $display("FAIL t5_stall: cyc %0d got v=%b d=%h rdy=%b want 01/0f000f00/00", k, rsp_valid, rsp_data, req_ready); else pass_cnt++;
         cyc();
      end
      rsp_ready = 2'b01; #1;
      total_cnt++; if (req_ready !== 2'b10) $display("FAIL t5_release: got %b want 10", req_ready); else pass_cnt++;
      cyc();
      req_valid = 2'b00; #1;
      total_cnt++; if (rsp_valid !== 2'b00 || alu_op !== ALU_OR)
         $display("FAIL t5_exec: got v=%b op=%0d want 00/%0d", rsp_valid, alu_op, ALU_OR); else pass_cnt++;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h00F0_000F)
         $display("FAIL t5_rsp1: got v=%b d=%h want 10/00f0000f", rsp_valid, rsp_data); else pass_cnt++;
      rsp_ready = 2'b10;
      cyc();
   endtask

   task automatic test_non_owner_ready();
      rsp_ready = 2'b10;
      req_op[0] = ALU_ADD; req_in1[0] = 32'd7; req_in2[0] = 32'd8;
      req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd15)
            $display("FAIL t6_hold: cyc %0d got v=%b d=%h want 01/f", k, rsp_valid, rsp_data); else pass_cnt++;
         cyc();
      end
      rsp_ready = 2'b01;
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL t6_consume: got %b want 00", rsp_valid); else pass_cnt++;
      rsp_ready = 2'b11;
      cyc(); cyc(); #1;
      total_cnt++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00)
         $display("FAIL t6_idle: got v=%b rdy=%b want 00/00", rsp_valid, req_ready); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_op = '{ALU_ADD, ALU_ADD}; req_in1 = '0; req_in2 = '0;
      test_reset_mid_op();
      test_single_latency();
      test_simultaneous();
      test_round_robin();
      test_backpressure();
      test_non_owner_ready();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
